// File: rtl/matrix_tx_if.sv
// Element-write, buffer-read and compiler handshake bundle for matrix_tx_controller.
// The master side is the controller; the slave side is the buffer/compiler/top-level environment.
interface matrix_tx_if #(
  parameter int DIM = 32
);
  localparam int AW = $clog2(DIM * DIM);
  localparam int LW = $clog2(DIM);

  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          valid_data_in;
  logic [LW-1:0] row_addr;
  logic [LW-1:0] col_addr;
  logic [7:0]    matrix_element;
  logic          data_request;
  logic          valid_data_out;

  modport master (
    input  start, rd_data, valid_data_out,
    output busy, done, error, rd_en, rd_addr, valid_data_in,
           row_addr, col_addr, matrix_element, data_request
  );

  modport slave (
    output start, rd_data, valid_data_out,
    input  busy, done, error, rd_en, rd_addr, valid_data_in,
           row_addr, col_addr, matrix_element, data_request
  );
endinterface

// File: rtl/matrix_tx_controller.sv
// Streams one DIM x DIM matrix from the result buffer into matrix_compiler as addressed
// element writes, then requests the serial stream and counts dibits until it completes.
module matrix_tx_controller #(
  parameter int DIM           = 32,
  parameter int RD_LATENCY    = 2,
  parameter int SETTLE_CYCLES = 7,
  parameter int TIMEOUT       = 4096
) (
  input logic        inter_refclk,
  input logic        rst,
  matrix_tx_if.master bus
);
  localparam int N    = DIM * DIM;
  localparam int AW   = $clog2(N);
  localparam int LW   = $clog2(DIM);
  localparam int CW   = $clog2(4 * N + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int WMAX = (RD_LATENCY > SETTLE_CYCLES) ? RD_LATENCY : SETTLE_CYCLES;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SETTLE,
    S_REQ,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [AW-1:0] addr;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] dibit_cnt;
  logic [TW-1:0] idle_cnt;
  logic          error_q;

  // Read address rides alongside the buffer latency so row/col line up with rd_data.
  logic [RD_LATENCY-1:0] pipe_v;
  logic [AW-1:0]         pipe_a [RD_LATENCY];

  logic load_last, drain_last, settle_last, stream_full, stream_timeout;

  assign load_last      = (addr == AW'(N - 1));
  assign drain_last     = (wait_cnt == WW'(RD_LATENCY - 1));
  assign settle_last    = (wait_cnt == WW'(SETTLE_CYCLES - 1));
  assign stream_full    = bus.valid_data_out && (dibit_cnt == CW'(4 * N - 1));
  assign stream_timeout = !bus.valid_data_out && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge inter_refclk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (bus.start) next_state = S_LOAD;
      S_LOAD:   if (load_last) next_state = S_DRAIN;
      S_DRAIN:  if (drain_last) next_state = S_SETTLE;
      S_SETTLE: if (settle_last) next_state = S_REQ;
      S_REQ:    next_state = S_STREAM;
      S_STREAM: if (stream_full || stream_timeout) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      addr      <= '0;
      wait_cnt  <= '0;
      dibit_cnt <= '0;
      idle_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          addr     <= '0;
          wait_cnt <= '0;
          if (bus.start) error_q <= 1'b0;
        end
        S_LOAD: begin
          addr     <= addr + 1'b1;
          wait_cnt <= '0;
        end
        S_DRAIN:  wait_cnt <= drain_last ? '0 : wait_cnt + 1'b1;
        S_SETTLE: wait_cnt <= wait_cnt + 1'b1;
        S_REQ: begin
          dibit_cnt <= '0;
          idle_cnt  <= '0;
        end
        S_STREAM: begin
          if (bus.valid_data_out) begin
            dibit_cnt <= dibit_cnt + 1'b1;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (stream_timeout) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= (state == S_LOAD);
      pipe_a[0] <= addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  always_comb begin
    bus.busy           = (state != S_IDLE);
    bus.done           = (state == S_DONE);
    bus.data_request   = (state == S_REQ);
    bus.error          = error_q;
    bus.rd_en          = (state == S_LOAD);
    bus.rd_addr        = (state == S_LOAD) ? addr : '0;
    bus.valid_data_in  = pipe_v[RD_LATENCY-1];
    bus.row_addr       = '0;
    bus.col_addr       = '0;
    bus.matrix_element = '0;
    if (pipe_v[RD_LATENCY-1]) begin
      bus.row_addr       = pipe_a[RD_LATENCY-1][AW-1:LW];
      bus.col_addr       = pipe_a[RD_LATENCY-1][LW-1:0];
      bus.matrix_element = bus.rd_data;
    end
  end
endmodule

// File: tb/tb_matrix_tx_controller.sv
// Bench for matrix_tx_controller: three DUTs (latency 2 / 1 / 4, one with a short timeout),
// each fed by a latency-accurate buffer model and a simple compiler model.
module tb_matrix_tx_controller;
  localparam int DIM    = 32;
  localparam int N      = DIM * DIM;
  localparam int SETTLE = 7;
  localparam int NI     = 3;
  localparam int LIMIT  = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] rst_v   = '0;
  logic [NI-1:0] vdo_v   = '0;

  wire [NI-1:0] busy_o, done_o, err_o, rden_o, vdi_o, dreq_o;
  wire [9:0]    rdaddr_o [NI];
  wire [4:0]    row_o    [NI];
  wire [4:0]    col_o    [NI];
  wire [7:0]    el_o     [NI];

  logic [7:0] mem [N];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    localparam int TO  = (g == 1) ? 50 : 4096;

    logic [7:0] sh [LAT];

    matrix_tx_if #(.DIM(DIM)) bus ();

    matrix_tx_controller #(
      .DIM(DIM), .RD_LATENCY(LAT), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TO)
    ) dut (
      .inter_refclk(clk),
      .rst(rst_v[g]),
      .bus(bus)
    );

    always @(posedge clk) begin
      sh[0] <= bus.rd_en ? mem[bus.rd_addr] : 8'h5C;
      for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
    end

    assign bus.start          = start_v[g];
    assign bus.valid_data_out = vdo_v[g];
    assign bus.rd_data        = sh[LAT-1];

    assign busy_o[g]   = bus.busy;
    assign done_o[g]   = bus.done;
    assign err_o[g]    = bus.error;
    assign rden_o[g]   = bus.rd_en;
    assign vdi_o[g]    = bus.valid_data_in;
    assign dreq_o[g]   = bus.data_request;
    assign rdaddr_o[g] = bus.rd_addr;
    assign row_o[g]    = bus.row_addr;
    assign col_o[g]    = bus.col_addr;
    assign el_o[g]     = bus.matrix_element;
  end

  function automatic int lat_of(input int g);
    return (g == 1) ? 1 : ((g == 2) ? 4 : 2);
  endfunction

  // Run configuration and observations of the most recent run.
  int   cfg_gap, cfg_dib, cfg_rst_wr;
  bit   cfg_noise, cfg_extra;
  int   ob_wr_n, ob_wr_bad, ob_first_wr, ob_last_wr, ob_wr_post;
  int   ob_req_n, ob_req_cyc, ob_done_n, ob_done_cyc, ob_dib_n, ob_last_dib;
  logic [4:0] ob_last_row, ob_last_col;
  logic [7:0] ob_last_el;
  logic ob_err_c1, ob_err_done, ob_err_p2, ob_busy_done, ob_busy_p1, ob_busy_p2;
  logic ob_rst_zero, ob_hung;

  task automatic configure(input int gap, input int dib, input int rst_wr, input bit noise, input bit extra);
    cfg_gap = gap; cfg_dib = dib; cfg_rst_wr = rst_wr; cfg_noise = noise; cfg_extra = extra;
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 0)      mem[i] = ((i / DIM) == (i % DIM)) ? 8'hAA : 8'hF0;
      else if (mode == 1) mem[i] = 8'(i);
      else                mem[i] = 8'($urandom);
    end
  endtask

  // Drives one start pulse, plays the compiler, and records what instance g did.
  // Cycle 0 is the cycle in which start is sampled.
  task automatic drive_run(input int g);
    int  rst_cyc;
    bit  stop;
    ob_wr_n = 0; ob_wr_bad = 0; ob_first_wr = -1; ob_last_wr = -1; ob_wr_post = 0;
    ob_req_n = 0; ob_req_cyc = -1; ob_done_n = 0; ob_done_cyc = -1; ob_dib_n = 0; ob_last_dib = -1;
    ob_last_row = '0; ob_last_col = '0; ob_last_el = '0;
    ob_err_c1 = 1'bx; ob_err_done = 1'bx; ob_err_p2 = 1'bx;
    ob_busy_done = 1'bx; ob_busy_p1 = 1'bx; ob_busy_p2 = 1'bx; ob_rst_zero = 1'b0;
    rst_cyc = -1;
    stop = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < LIMIT && !stop; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start_v[g] = 1'b0;
      vdo_v[g]   = 1'b0;
      if (rst_cyc >= 0) begin
        rst_v[g] = 1'b0;
        if (cyc == rst_cyc + 1)
          ob_rst_zero = ({busy_o[g], done_o[g], err_o[g], rden_o[g], vdi_o[g], dreq_o[g]} == 6'b0)
                        && rdaddr_o[g] == 10'd0 && row_o[g] == 5'd0 && col_o[g] == 5'd0
                        && el_o[g] == 8'd0;
        else if (vdi_o[g]) ob_wr_post++;
        if (cyc == rst_cyc + 30) stop = 1'b1;
      end else begin
        if (cyc == 1) ob_err_c1 = err_o[g];
        if (vdi_o[g]) begin
          if (ob_wr_n >= N || row_o[g] != 5'(ob_wr_n / DIM) || col_o[g] != 5'(ob_wr_n % DIM)
              || el_o[g] != mem[ob_wr_n % N])
            ob_wr_bad++;
          if (ob_first_wr < 0) ob_first_wr = cyc;
          ob_last_wr  = cyc;
          ob_last_row = row_o[g];
          ob_last_col = col_o[g];
          ob_last_el  = el_o[g];
          ob_wr_n++;
        end
        if (dreq_o[g]) begin ob_req_n++; ob_req_cyc = cyc; end
        if (done_o[g]) begin
          ob_done_n++; ob_done_cyc = cyc; ob_err_done = err_o[g]; ob_busy_done = busy_o[g];
        end
        if (ob_done_n > 0 && cyc == ob_done_cyc + 1) ob_busy_p1 = busy_o[g];
        if (ob_done_n > 0 && cyc == ob_done_cyc + 2) begin
          ob_busy_p2 = busy_o[g]; ob_err_p2 = err_o[g]; stop = 1'b1;
        end
        if (cyc == 0) start_v[g] = 1'b1;
        if (cfg_extra && (cyc == 101 || (ob_req_n > 0 && cyc == ob_req_cyc + 5)
                          || (ob_done_n > 0 && cyc == ob_done_cyc)))
          start_v[g] = 1'b1;
        if (ob_req_n > 0 && cyc > ob_req_cyc) begin
          if (ob_dib_n < cfg_dib && ((cyc - ob_req_cyc - 1) % cfg_gap) == 0) begin
            vdo_v[g] = 1'b1; ob_dib_n++; ob_last_dib = cyc;
          end
        end else if (cfg_noise && ob_req_n == 0) begin
          vdo_v[g] = 1'($urandom_range(0, 1));
        end
        if (cfg_rst_wr >= 0 && ob_wr_n == cfg_rst_wr) begin
          rst_v[g] = 1'b1; rst_cyc = cyc;
        end
      end
    end
    ob_hung = !stop;
    start_v[g] = 1'b0; vdo_v[g] = 1'b0; rst_v[g] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_v = '1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      tests++;
      if ({busy_o[g], done_o[g], err_o[g], rden_o[g], vdi_o[g], dreq_o[g]} !== 6'b0
          || rdaddr_o[g] !== 10'd0 || el_o[g] !== 8'd0 || row_o[g] !== 5'd0 || col_o[g] !== 5'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: busy=%b done=%b err=%b rd_en=%b vdi=%b dreq=%b addr=%0d el=%0h, required all 0",
                 g, busy_o[g], done_o[g], err_o[g], rden_o[g], vdi_o[g], dreq_o[g], rdaddr_o[g], el_o[g]);
      end
    end
    rst_v = '0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    fill_mem(0);
    configure(1, 4096, -1, 1'b1, 1'b0);
    drive_run(0);
    tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL nom_hung: run did not finish in %0d cycles", LIMIT); end
    tests++; if (ob_wr_n !== N) begin fails++; $display("FAIL nom_writes: got %0d required %0d", ob_wr_n, N); end
    tests++; if (ob_wr_bad !== 0) begin fails++; $display("FAIL nom_contents: %0d bad writes, required 0", ob_wr_bad); end
    tests++;
    if ({ob_last_row, ob_last_col, ob_last_el} !== {5'd31, 5'd31, 8'hAA}) begin
      fails++;
      $display("FAIL nom_last: got (%0d,%0d)=%0h required (31,31)=aa", ob_last_row, ob_last_col, ob_last_el);
    end
    tests++; if (ob_first_wr !== 1 + 2) begin fails++; $display("FAIL nom_first_write: cycle %0d required 3", ob_first_wr); end
    tests++;
    if (ob_last_wr - ob_first_wr !== N - 1) begin
      fails++; $display("FAIL nom_contiguous: span %0d required %0d", ob_last_wr - ob_first_wr, N - 1);
    end
    tests++; if (ob_req_n !== 1) begin fails++; $display("FAIL nom_req_count: got %0d required 1", ob_req_n); end
    tests++; if (ob_req_cyc !== 1034) begin fails++; $display("FAIL nom_req_cycle: got %0d required 1034", ob_req_cyc); end
    tests++; if (ob_done_n !== 1) begin fails++; $display("FAIL nom_done_count: got %0d required 1", ob_done_n); end
    tests++;
    if (ob_done_cyc !== ob_last_dib + 1) begin
      fails++; $display("FAIL nom_done_cycle: got %0d required %0d", ob_done_cyc, ob_last_dib + 1);
    end
    tests++;
    if ({ob_busy_done, ob_busy_p1, ob_err_done} !== 3'b100) begin
      fails++; $display("FAIL nom_busy_err: busy@done=%b busy@done+1=%b err=%b required 1,0,0",
                        ob_busy_done, ob_busy_p1, ob_err_done);
    end
  endtask

  task automatic test_alignment();
    fill_mem(1);
    configure(1, 4096, -1, 1'b0, 1'b0);
    for (int g = 1; g < NI; g++) begin
      drive_run(g);
      tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL align_hung[%0d]: no finish", g); end
      tests++; if (ob_wr_n !== N) begin fails++; $display("FAIL align_writes[%0d]: got %0d required %0d", g, ob_wr_n, N); end
      tests++; if (ob_wr_bad !== 0) begin fails++; $display("FAIL align_contents[%0d]: %0d bad writes, required 0", g, ob_wr_bad); end
      tests++;
      if (ob_first_wr !== 1 + lat_of(g)) begin
        fails++; $display("FAIL align_first[%0d]: cycle %0d required %0d", g, ob_first_wr, 1 + lat_of(g));
      end
      tests++;
      if (ob_req_cyc !== N + lat_of(g) + SETTLE + 1) begin
        fails++; $display("FAIL align_req[%0d]: cycle %0d required %0d", g, ob_req_cyc, N + lat_of(g) + SETTLE + 1);
      end
    end
  endtask

  task automatic test_ignored_start();
    fill_mem(2);
    configure(1, 4096, -1, 1'b0, 1'b1);
    drive_run(0);
    tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL ign_hung: no finish"); end
    tests++; if (ob_wr_n !== N) begin fails++; $display("FAIL ign_writes: got %0d required %0d", ob_wr_n, N); end
    tests++; if (ob_wr_bad !== 0) begin fails++; $display("FAIL ign_contents: %0d bad writes, required 0", ob_wr_bad); end
    tests++;
    if (ob_req_n !== 1 || ob_done_n !== 1) begin
      fails++; $display("FAIL ign_pulses: req=%0d done=%0d required 1,1", ob_req_n, ob_done_n);
    end
    tests++;
    if ({ob_busy_p1, ob_busy_p2} !== 2'b00) begin
      fails++; $display("FAIL ign_after_done: busy=%b%b required 00", ob_busy_p1, ob_busy_p2);
    end
  endtask

  task automatic test_gapped();
    fill_mem(2);
    configure(3, 4096, -1, 1'b0, 1'b0);
    drive_run(0);
    tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL gap_hung: no finish"); end
    tests++; if (ob_done_n !== 1) begin fails++; $display("FAIL gap_done_count: got %0d required 1", ob_done_n); end
    tests++;
    if (ob_done_cyc !== ob_last_dib + 1) begin
      fails++; $display("FAIL gap_done_cycle: got %0d required %0d", ob_done_cyc, ob_last_dib + 1);
    end
    tests++; if (ob_err_done !== 1'b0) begin fails++; $display("FAIL gap_error: got %b required 0", ob_err_done); end
  endtask

  task automatic test_timeout();
    fill_mem(2);
    configure(1, 100, -1, 1'b0, 1'b0);
    drive_run(1);
    tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL to_hung: no finish"); end
    tests++; if (ob_err_done !== 1'b1) begin fails++; $display("FAIL to_error: got %b required 1", ob_err_done); end
    tests++;
    if (ob_done_cyc !== ob_last_dib + 50 + 1) begin
      fails++; $display("FAIL to_done_cycle: got %0d required %0d", ob_done_cyc, ob_last_dib + 51);
    end
    tests++;
    if ({ob_busy_p1, ob_err_p2} !== 2'b01) begin
      fails++; $display("FAIL to_idle_sticky: busy=%b err=%b required 0,1", ob_busy_p1, ob_err_p2);
    end
    configure(1, 4096, -1, 1'b0, 1'b0);
    drive_run(1);
    tests++;
    if ({ob_err_c1, ob_err_done} !== 2'b00) begin
      fails++; $display("FAIL to_clear: err after start=%b err at done=%b required 0,0", ob_err_c1, ob_err_done);
    end
    tests++;
    if (ob_done_cyc !== ob_last_dib + 1) begin
      fails++; $display("FAIL to_rerun_done: got %0d required %0d", ob_done_cyc, ob_last_dib + 1);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem(2);
    configure(1, 4096, 500, 1'b0, 1'b0);
    drive_run(0);
    tests++; if (ob_hung !== 1'b0) begin fails++; $display("FAIL rm_hung: no finish"); end
    tests++; if (ob_rst_zero !== 1'b1) begin fails++; $display("FAIL rm_outputs: all-zero=%b required 1", ob_rst_zero); end
    tests++; if (ob_wr_post !== 0) begin fails++; $display("FAIL rm_post_writes: got %0d required 0", ob_wr_post); end
    tests++; if (ob_wr_bad !== 0) begin fails++; $display("FAIL rm_pre_contents: %0d bad writes, required 0", ob_wr_bad); end
    fill_mem(1);
    configure(1, 4096, -1, 1'b0, 1'b0);
    drive_run(0);
    tests++;
    if (ob_wr_n !== N || ob_wr_bad !== 0) begin
      fails++; $display("FAIL rm_fresh_run: writes=%0d bad=%0d required %0d,0", ob_wr_n, ob_wr_bad, N);
    end
    tests++;
    if (ob_done_n !== 1 || ob_req_cyc !== 1034) begin
      fails++; $display("FAIL rm_fresh_timing: done=%0d req=%0d required 1,1034", ob_done_n, ob_req_cyc);
    end
  endtask

  initial begin
    fill_mem(0);
    test_reset();
    test_nominal();
    test_alignment();
    test_ignored_start();
    test_gapped();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
